cpu_mc: RTL and testbench
=========================

CPU_MC -- requirements
Module: cpu_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 16: datapath and register width, 8..32.
REQ-002 SHALL have parameter ADDR_W, default 16: instruction and data address width, 8..DATA_W.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port i_req, output, 1: instruction fetch request.
REQ-006 SHALL have port i_addr, output, ADDR_W: fetch address, equal to PC.
REQ-007 SHALL have port i_data, input, 16: instruction word, valid in the cycle i_ack=1.
REQ-008 SHALL have port i_ack, input, 1: fetch complete.
REQ-009 SHALL have port d_req, output, 1: data memory request.
REQ-010 SHALL have port d_we, output, 1: 1 = write, 0 = read; valid while d_req=1.
REQ-011 SHALL have port d_addr, output, ADDR_W: data address.
REQ-012 SHALL have port d_wdata, output, DATA_W: store data.
REQ-013 SHALL have port d_rdata, input, DATA_W: load data, valid in the cycle d_ack=1.
REQ-014 SHALL have port d_ack, input, 1: data access complete.
REQ-015 SHALL have port halted, output, 1: 1 while in HALT.
REQ-016 SHALL have port led, output, 8: R1[7:0].

Function
REQ-017 SHALL contain 16 registers R0..R15 of DATA_W bits, a PC of ADDR_W bits, and flags Z and C; R0 is an ordinary register.
REQ-018 SHALL decode the instruction as op=[15:12], rd=[11:8], ra=[7:4], rb=[3:0], imm8=[7:0].
REQ-019 SHALL implement opcodes 0 NOP; 1 ADD rd=ra+rb; 2 SUB rd=ra-rb; 3 AND; 4 OR; 5 XOR; 6 SHL rd=ra<<1; 7 SHR rd=ra>>1 (logical); 8 LDI rd=zero-extended imm8; 9 LD rd=mem[ra]; A ST mem[ra]=rb; B CMP; C JMP pc=ra; D BZ (pc=ra if Z); E BLT (pc=ra if C); F HALT.
REQ-020 SHALL truncate all arithmetic modulo 2^DATA_W, and addresses taken from registers to bits [ADDR_W-1:0].
REQ-021 SHALL on CMP set Z=(ra==rb) and C=(ra<rb, unsigned); no other instruction changes Z or C.
REQ-022 SHALL use a state machine FETCH -> EXEC -> (MEM ->) FETCH, plus HALT.
REQ-023 FETCH: i_req=1 with i_addr=PC, held stable until i_ack; on i_ack latch i_data, PC=PC+1 (wrapping at 2^ADDR_W), go to EXEC.
REQ-024 EXEC: ALU, LDI, CMP, NOP, jump and branch complete in this one cycle, then FETCH; LD and ST go to MEM; HALT goes to HALT.
REQ-025 Jump/branch SHALL overwrite the already-incremented PC when taken; not-taken leaves PC+1.
REQ-026 MEM: d_req=1, d_addr=ra, d_we=1 for ST with d_wdata=rb; d_req/d_we/d_addr/d_wdata held stable until d_ack; on d_ack LD writes d_rdata to rd; then FETCH.
REQ-027 SHALL ignore i_ack outside FETCH and d_ack outside MEM.
REQ-028 Minimum instruction latency with zero-wait memory (ack in first request cycle): 2 cycles, LD/ST 3 cycles.
REQ-029 SHALL read operands before write, so rd equal to ra or rb uses the old value.
REQ-030 HALT SHALL be left only via rst; i_req=d_req=0 there.

Reset
REQ-031 With rst=1 at a clock edge: PC=0, all registers=0, Z=C=0, state=FETCH; i_req asserts the cycle after rst deasserts.
REQ-032 During rst and while rst=1: i_req=0, d_req=0, d_we=0, halted=0, led=0; rst aborts any pending fetch or data access with no register write.

Verification
REQ-033 LDI R1,0x05; LDI R2,0x03; ADD R1,R1,R2 with zero-wait memory -> led=0x08 after 6 cycles of execution, PC=3.
REQ-034 LDI R3,0x10; LDI R4,0xAB; ST [R3],R4 with d_ack delayed 3 cycles -> d_req, d_we=1, d_addr=0x0010, d_wdata=0x00AB stable over 4 cycles; single write.
REQ-035 LDI R1,0; SUB R1,R1,R1 then LDI R2,1; SUB R1,R1,R2 -> R1=0xFFFF (DATA_W=16); DATA_W=8 build -> 0xFF.
REQ-036 CMP R5=3,R6=7 then BLT R7=0x20 -> C=1, Z=0, next i_addr=0x0020; CMP 7,7 then BLT -> falls through, Z=1.
REQ-037 PC at 0xFFFF executing NOP -> next i_addr=0x0000.
REQ-038 rst pulsed while d_req=1 awaiting d_ack -> next cycle d_req=0, registers 0, fetch restarts at i_addr=0; HALT -> halted=1, no further i_req until rst.

Source files
------------

// File: rtl/cpu_mc.sv
// Multi-cycle 16-register CPU: FETCH -> EXEC -> (MEM ->) FETCH, plus a terminal HALT.
// Separate request/acknowledge instruction and data buses; all state is reset synchronously.
module cpu_mc #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              i_req,
  output logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_data,
  input  logic              i_ack,
  output logic              d_req,
  output logic              d_we,
  output logic [ADDR_W-1:0] d_addr,
  output logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W-1:0] d_rdata,
  input  logic              d_ack,
  output logic              halted,
  output logic [7:0]        led
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR,  OP_XOR, OP_SHL, OP_SHR,
    OP_LDI, OP_LD,  OP_ST,  OP_CMP, OP_JMP, OP_BZ,  OP_BLT, OP_HALT
  } op_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] regs [16];
  logic [ADDR_W-1:0] pc;
  logic [15:0]       ir;
  logic              flag_z, flag_c;

  op_t               op;
  logic [3:0]        rd, ra, rb;
  logic [DATA_W-1:0] va, vb, alu_y;
  logic              alu_wr, jump_taken;

  assign op = op_t'(ir[15:12]);
  assign rd = ir[11:8];
  assign ra = ir[7:4];
  assign rb = ir[3:0];
  assign va = regs[ra];
  assign vb = regs[rb];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FETCH: if (i_ack) state_nxt = S_EXEC;
      S_EXEC: begin
        if (op == OP_LD || op == OP_ST) state_nxt = S_MEM;
        else if (op == OP_HALT)         state_nxt = S_HALT;
        else                            state_nxt = S_FETCH;
      end
      S_MEM:   if (d_ack) state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Bus strobes; forced low while rst is held so an aborted access vanishes immediately
  always_comb begin
    i_req  = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
    halted = 1'b0;
    if (!rst) begin
      unique case (state)
        S_FETCH: i_req = 1'b1;
        S_MEM: begin
          d_req = 1'b1;
          d_we  = (op == OP_ST);
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  // Address/data come straight from PC and the register file, which are frozen while waiting
  assign i_addr  = pc;
  assign d_addr  = va[ADDR_W-1:0];
  assign d_wdata = vb;
  assign led     = rst ? 8'h00 : regs[1][7:0];

  // NOTE: every variable assigned in a combinational block gets a default first; otherwise latches are inferred.
  always_comb begin
    alu_y  = '0;
    alu_wr = 1'b1;
    unique case (op)
      OP_ADD:  alu_y = va + vb;
      OP_SUB:  alu_y = va - vb;
      OP_AND:  alu_y = va & vb;
      OP_OR:   alu_y = va | vb;
      OP_XOR:  alu_y = va ^ vb;
      OP_SHL:  alu_y = {va[DATA_W-2:0], 1'b0};
      OP_SHR:  alu_y = {1'b0, va[DATA_W-1:1]};
      OP_LDI:  alu_y = DATA_W'(ir[7:0]);
      default: alu_wr = 1'b0;
    endcase
  end

  assign jump_taken = (op == OP_JMP) || (op == OP_BZ && flag_z) || (op == OP_BLT && flag_c);

  // NOTE: sequential state uses non-blocking assignments so operands read this cycle are the old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      ir     <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      // NOTE: the register file must power up as zeros, so it is reset explicitly rather than left as RAM.
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (i_ack) begin
            ir <= i_data;
            pc <= pc + ADDR_W'(1);
          end
        end
        S_EXEC: begin
          if (alu_wr) regs[rd] <= alu_y;
          if (op == OP_CMP) begin
            flag_z <= (va == vb);
            flag_c <= (va < vb);
          end
          // Taken branches overwrite the PC that FETCH already advanced
          if (jump_taken) pc <= va[ADDR_W-1:0];
        end
        S_MEM:   if (d_ack && op == OP_LD) regs[rd] <= d_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mc.sv
// Self-checking bench for cpu_mc: directed programs plus a random program, all compared
// against an instruction-level model of the ISA driven by the bench acting as both memories.
module tb_cpu_mc;

  logic        clk;
  logic        rst;
  logic        i_req, i_ack;
  logic [15:0] i_addr, i_data;
  logic        d_req, d_we, d_ack;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        halted;
  logic [7:0]  led;

  cpu_mc #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .halted(halted), .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Environment memories and ISA-level model state
  logic [15:0] imem [65536];
  logic [15:0] dmem [65536];
  logic [15:0] m_r [16];
  logic [15:0] m_pc;
  logic        m_z, m_c, m_halt;

  // Pending data access expected from the current instruction
  logic        exp_mem, exp_we;
  logic [15:0] exp_addr, exp_wdata;
  logic [3:0]  exp_rd;
  logic        in_exec, in_mem;

  int          cyc;
  int          dreq_cycles;
  int          fetch_cyc[$];
  logic [15:0] fetch_addr[$];
  logic [15:0] last_st_addr, last_st_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 16'h0;
    m_pc = 16'h0; m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
    exp_mem = 1'b0; exp_we = 1'b0; exp_addr = 16'h0; exp_wdata = 16'h0; exp_rd = 4'h0;
    in_exec = 1'b0; in_mem = 1'b0;
    cyc = 0; dreq_cycles = 0;
    fetch_cyc.delete(); fetch_addr.delete();
  endtask

  // Architectural effect of one instruction; PC has already been advanced by the caller
  task automatic model_exec(input logic [15:0] ins);
    logic [3:0]  op, rd;
    logic [15:0] a, b;
    op = ins[15:12]; rd = ins[11:8];
    a = m_r[ins[7:4]]; b = m_r[ins[3:0]];
    exp_mem = 1'b0;
    case (op)
      4'h1: m_r[rd] = a + b;
      4'h2: m_r[rd] = a - b;
      4'h3: m_r[rd] = a & b;
      4'h4: m_r[rd] = a | b;
      4'h5: m_r[rd] = a ^ b;
      4'h6: m_r[rd] = a << 1;
      4'h7: m_r[rd] = a >> 1;
      4'h8: m_r[rd] = {8'h00, ins[7:0]};
      4'h9: begin exp_mem = 1'b1; exp_we = 1'b0; exp_addr = a; exp_rd = rd; end
      4'hA: begin exp_mem = 1'b1; exp_we = 1'b1; exp_addr = a; exp_wdata = b; end
      4'hB: begin m_z = (a == b); m_c = (a < b); end
      4'hC: m_pc = a;
      4'hD: if (m_z) m_pc = a;
      4'hE: if (m_c) m_pc = a;
      4'hF: m_halt = 1'b1;
      default: ;
    endcase
  endtask

  // Serve the buses cycle by cycle until n instructions have been fetched
  task automatic run_fetches(input int n, input int iw_lo, input int iw_hi,
                             input int dw_lo, input int dw_hi);
    int fetched = 0;
    int budget  = 0;
    int iw = int'($urandom_range(iw_hi, iw_lo));
    int dw = 0;
    logic [15:0] ins;
    while (fetched < n) begin
      @(negedge clk);
      cyc++; budget++;
      i_ack = 1'b0; d_ack = 1'b0;
      i_data = 16'($urandom); d_rdata = 16'($urandom);
      if (d_req === 1'b1) dreq_cycles++;
      if (budget > 4000) begin
        check("cycle_budget", 64'(budget), 64'(0));
        break;
      end
      if (in_exec) begin
        check("exec_idle", 64'({i_req, d_req, halted}), 64'(3'b000));
        i_ack = 1'($urandom_range(0, 1));
        d_ack = 1'($urandom_range(0, 1));
        in_exec = 1'b0;
        in_mem  = exp_mem;
        dw = int'($urandom_range(dw_hi, dw_lo));
      end else if (in_mem) begin
        check("mem_bus",
              64'({i_req, d_req, d_we, d_addr, (exp_we ? d_wdata : 16'h0)}),
              64'({1'b0, 1'b1, exp_we, exp_addr, (exp_we ? exp_wdata : 16'h0)}));
        i_ack = 1'($urandom_range(0, 1));
        if (dw == 0) begin
          d_ack  = 1'b1;
          in_mem = 1'b0;
          if (exp_we) begin
            dmem[exp_addr] = exp_wdata;
            last_st_addr = d_addr;
            last_st_data = d_wdata;
          end else begin
            d_rdata = dmem[exp_addr];
            m_r[exp_rd] = dmem[exp_addr];
          end
        end else dw--;
      end else begin
        check("fetch_bus", 64'({i_req, d_req, halted, i_addr, led}),
              64'({3'b100, m_pc, m_r[1][7:0]}));
        d_ack = 1'($urandom_range(0, 1));
        if (iw == 0) begin
          ins = imem[m_pc];
          i_ack = 1'b1; i_data = ins;
          fetch_cyc.push_back(cyc);
          fetch_addr.push_back(i_addr);
          m_pc = m_pc + 16'h1;
          model_exec(ins);
          fetched++;
          in_exec = 1'b1;
          iw = int'($urandom_range(iw_hi, iw_lo));
        end else iw--;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_ack = 1'b0; d_ack = 1'b0;
    #1 check("rst_outputs", 64'({i_req, d_req, d_we, halted, led}), 64'(12'h000));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_fetch", 64'({i_req, d_req, halted, i_addr, led}), 64'({3'b100, 16'h0, 8'h00}));
    model_reset();
  endtask

  initial begin
    rst = 1'b1; i_ack = 1'b0; d_ack = 1'b0; i_data = 16'h0; d_rdata = 16'h0;
    last_st_addr = 16'h0; last_st_data = 16'h0;
    for (int i = 0; i < 65536; i++) begin imem[i] = 16'h0000; dmem[i] = 16'h0000; end
    model_reset();

    // Add sequence with zero-wait memory, then a store, checking latencies
    imem[0] = 16'h8105; imem[1] = 16'h8203; imem[2] = 16'h1112; imem[3] = 16'hA021; imem[4] = 16'h0000;
    do_reset();
    run_fetches(5, 0, 0, 0, 0);
    check("add_fetch_addr3", 64'(fetch_addr[3]), 64'(16'h0003));
    check("add_latency", 64'(fetch_cyc[3] - fetch_cyc[0]), 64'(6));
    check("st_latency", 64'(fetch_cyc[4] - fetch_cyc[3]), 64'(3));
    check("add_led", 64'(led), 64'(8'h08));

    // Store with data acknowledge delayed three cycles
    imem[0] = 16'h8310; imem[1] = 16'h84AB; imem[2] = 16'hA034; imem[3] = 16'h0000;
    do_reset();
    run_fetches(4, 0, 0, 3, 3);
    check("st_dreq_cycles", 64'(dreq_cycles), 64'(4));
    check("st_addr", 64'(last_st_addr), 64'(16'h0010));
    check("st_data", 64'(last_st_data), 64'(16'h00AB));

    // Compare and branch: taken BLT, then not-taken BLT with Z set, then taken BZ
    imem[0]     = 16'h8503; imem[1]     = 16'h8607; imem[2]     = 16'h8720;
    imem[3]     = 16'hB056; imem[4]     = 16'hE070;
    imem[16'h20] = 16'h8507; imem[16'h21] = 16'hB056; imem[16'h22] = 16'h8740;
    imem[16'h23] = 16'hE070; imem[16'h24] = 16'hD070; imem[16'h40] = 16'h0000;
    do_reset();
    run_fetches(11, 0, 1, 0, 1);
    check("blt_taken", 64'(fetch_addr[5]), 64'(16'h0020));
    check("blt_fallthru", 64'(fetch_addr[9]), 64'(16'h0024));
    check("bz_taken", 64'(fetch_addr[10]), 64'(16'h0040));

    // Subtraction wrap to all ones, jump to the top address, PC wrap to zero
    imem[0] = 16'h8100; imem[1] = 16'h2111; imem[2] = 16'h8201; imem[3] = 16'h2112;
    imem[4] = 16'hC010; imem[16'hFFFF] = 16'h0000;
    do_reset();
    run_fetches(6, 0, 1, 0, 0);
    check("sub_wrap_led", 64'(led), 64'(8'hFF));
    check("jmp_top", 64'(fetch_addr[5]), 64'(16'hFFFF));
    run_fetches(1, 0, 1, 0, 0);
    check("pc_wrap", 64'(fetch_addr[6]), 64'(16'h0000));

    // Reset arriving while a store waits for its acknowledge
    imem[0] = 16'h815A; imem[1] = 16'h8310; imem[2] = 16'hA031;
    do_reset();
    run_fetches(3, 0, 0, 0, 0);
    @(negedge clk); i_ack = 1'b0; d_ack = 1'b0;
    check("abort_exec", 64'({i_req, d_req}), 64'(2'b00));
    @(negedge clk);
    check("abort_pending", 64'({d_req, d_we, led}), 64'({2'b11, 8'h5A}));
    do_reset();

    // Random program against the model, with random wait states and stray acknowledges
    for (int i = 0; i < 65536; i++) begin
      imem[i] = 16'($urandom);
      if (imem[i][15:12] == 4'hF) imem[i][15:12] = 4'h0;
      dmem[i] = 16'($urandom);
    end
    do_reset();
    run_fetches(400, 0, 2, 0, 3);

    // HALT holds until reset
    imem[0] = 16'h8177; imem[1] = 16'hF000;
    do_reset();
    run_fetches(2, 0, 1, 0, 0);
    @(negedge clk); i_ack = 1'b1; d_ack = 1'b1;
    check("halt_exec", 64'({halted, i_req}), 64'(2'b00));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      i_ack = 1'($urandom_range(0, 1)); d_ack = 1'($urandom_range(0, 1));
      check("halt_hold", 64'({halted, i_req, d_req, led}), 64'({3'b100, 8'h77}));
    end
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
